// File: rtl/multi_channel_sample_ring.sv
// multi_channel_sample_ring: CHANNELS independent circular sample rings packed into one simple-dual-port RAM.
// Optional feature: define RING_CLEAR_EN to add the clr_i port and a sweep that zeroes the whole memory.
module multi_channel_sample_ring #(
    parameter int    WIDTH           = 16,
    parameter int    DEPTH           = 1024,
    parameter int    CHANNELS        = 2,
    parameter string RAM_PERFORMANCE = "LOW_LATENCY",
    parameter string WRITE_MODE      = "READ_FIRST",
    localparam int   AW              = $clog2(DEPTH),
    localparam int   CW              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clka_i,
    input  logic             rsta_n_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [CW-1:0]    wr_chan_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_valid_i,
    input  logic [CW-1:0]    rd_chan_i,
    input  logic [AW-1:0]    rd_delay_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_data_valid_o,
    output logic             rd_underflow_o
`ifdef RING_CLEAR_EN
    ,
    input  logic             clr_i
`endif
);
    localparam int          MAW  = CW + AW;
    localparam int          NE   = CHANNELS * DEPTH;
    localparam logic [CW:0] CH_N = (CW + 1)'(CHANNELS);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam bit          WF   = (WRITE_MODE == "WRITE_FIRST");

    logic [WIDTH-1:0] mem [NE];
    logic [AW-1:0]    wp_q [CHANNELS];
    logic [AW:0]      fill_q [CHANNELS];
    logic             wr_ready_q, wr_ready_d;
    logic             wr_fire, clr_go;
    logic             mem_we;
    logic [MAW-1:0]   mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic             rd_uf;
    logic [MAW-1:0]   rd_addr;
    logic [WIDTH-1:0] rd_val;
    logic             s_valid, s_uf;
    logic [WIDTH-1:0] s_data;
    logic             rd_data_valid_q, rd_underflow_q;
    logic [WIDTH-1:0] rd_data_q;

    // A write is taken only for an existing channel; a clr on the same edge wins
    assign wr_fire = wr_valid_i & wr_ready_q & ({1'b0, wr_chan_i} < CH_N) & ~clr_go;

`ifdef RING_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t         state_q, state_d;
    logic [MAW-1:0] clr_cnt_q, clr_cnt_d;

    // State register and sweep address counter
    always_ff @(posedge clka_i) begin
        if (!rsta_n_i) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: clr in IDLE starts the sweep, the last address ends it
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        if (state_q == IDLE) begin
            state_d = clr_i ? CLEAR : IDLE;
        end else begin
            state_d   = (clr_cnt_q == MAW'(NE - 1)) ? IDLE : CLEAR;
            clr_cnt_d = (clr_cnt_q == MAW'(NE - 1)) ? '0 : clr_cnt_q + 1'b1;
        end
    end

    // Outputs: the sweep owns the RAM write port while clearing
    always_comb begin
        clr_go     = (state_q == IDLE) & clr_i;
        wr_ready_d = (state_d == IDLE);
        mem_we     = (state_q == CLEAR) | wr_fire;
        mem_wa     = (state_q == CLEAR) ? clr_cnt_q : {wr_chan_i, wp_q[wr_chan_i]};
        mem_wd     = (state_q == CLEAR) ? '0 : wr_data_i;
    end
`else
    // Without the clear sweep the RAM write port belongs to the producer
    always_comb begin
        clr_go     = 1'b0;
        wr_ready_d = 1'b1;
        mem_we     = wr_fire;
        mem_wa     = {wr_chan_i, wp_q[wr_chan_i]};
        mem_wd     = wr_data_i;
    end
`endif

    // Per-channel write pointer and saturating fill level
    always_ff @(posedge clka_i) begin
        if (!rsta_n_i || clr_go) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wp_q[c]   <= '0;
                fill_q[c] <= '0;
            end
        end else if (wr_fire) begin
            wp_q[wr_chan_i]   <= wp_q[wr_chan_i] + 1'b1;
            fill_q[wr_chan_i] <= (fill_q[wr_chan_i] == FULL) ? FULL : fill_q[wr_chan_i] + 1'b1;
        end
    end

    // Producer handshake
    always_ff @(posedge clka_i) begin
        if (!rsta_n_i) wr_ready_q <= 1'b0;
        else           wr_ready_q <= wr_ready_d;
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clka_i) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Tap address from the pre-write pointer; collision forwarding only in WRITE_FIRST
    always_comb begin
        rd_addr = {rd_chan_i, AW'(wp_q[rd_chan_i] - rd_delay_i - 1'b1)};
        rd_uf   = ({1'b0, rd_chan_i} >= CH_N) || ({1'b0, rd_delay_i} >= fill_q[rd_chan_i]);
        rd_val  = rd_uf ? '0 : ((WF && mem_we && mem_wa == rd_addr) ? mem_wd : mem[rd_addr]);
    end

    generate
        if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_hp
            logic             p1_valid_q, p1_uf_q;
            logic [WIDTH-1:0] p1_data_q;
            // RAM read register stage ahead of the output register
            always_ff @(posedge clka_i) begin
                if (!rsta_n_i) begin
                    p1_valid_q <= 1'b0;
                    p1_uf_q    <= 1'b0;
                    p1_data_q  <= '0;
                end else begin
                    p1_valid_q <= rd_valid_i;
                    if (rd_valid_i) begin
                        p1_uf_q   <= rd_uf;
                        p1_data_q <= rd_val;
                    end
                end
            end
            assign s_valid = p1_valid_q;
            assign s_uf    = p1_uf_q;
            assign s_data  = p1_data_q;
        end else begin : g_ll
            assign s_valid = rd_valid_i;
            assign s_uf    = rd_uf;
            assign s_data  = rd_val;
        end
    endgenerate

    // Output register: loads only qualified results, holds otherwise
    always_ff @(posedge clka_i) begin
        if (!rsta_n_i) begin
            rd_data_valid_q <= 1'b0;
            rd_underflow_q  <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            rd_data_valid_q <= s_valid;
            if (s_valid) begin
                rd_underflow_q <= s_uf;
                rd_data_q      <= s_data;
            end
        end
    end

    assign wr_ready_o      = wr_ready_q;
    assign rd_data_o       = rd_data_q;
    assign rd_data_valid_o = rd_data_valid_q;
    assign rd_underflow_o  = rd_underflow_q;
endmodule

// File: tb/tb_multi_channel_sample_ring.sv
// tb_multi_channel_sample_ring: directed checks of a LOW_LATENCY/READ_FIRST and a HIGH_PERFORMANCE/WRITE_FIRST ring side by side.
module tb_multi_channel_sample_ring;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rsta_n = 1'b0, wr_valid = 1'b0, rd_valid = 1'b0, wr_chan = 1'b0, rd_chan = 1'b0;
    logic [15:0] wr_data = '0;
    logic [2:0]  rd_delay = '0;
`ifdef RING_CLEAR_EN
    logic        clr = 1'b0;
`endif
    logic        ll_ready, hp_ready, ll_v, hp_v, ll_uf, hp_uf;
    logic [15:0] ll_d, hp_d;
    int          n_vec = 0, n_err = 0;
    logic [15:0] ch0_newest = 16'h0033;

    multi_channel_sample_ring #(.WIDTH(16), .DEPTH(8), .CHANNELS(2),
        .RAM_PERFORMANCE("LOW_LATENCY"), .WRITE_MODE("READ_FIRST")) u_ll (
        .clka_i(clk), .rsta_n_i(rsta_n), .wr_valid_i(wr_valid), .wr_ready_o(ll_ready),
        .wr_chan_i(wr_chan), .wr_data_i(wr_data), .rd_valid_i(rd_valid), .rd_chan_i(rd_chan),
        .rd_delay_i(rd_delay), .rd_data_o(ll_d), .rd_data_valid_o(ll_v), .rd_underflow_o(ll_uf)
`ifdef RING_CLEAR_EN
        , .clr_i(clr)
`endif
    );

    multi_channel_sample_ring #(.WIDTH(16), .DEPTH(8), .CHANNELS(2),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .WRITE_MODE("WRITE_FIRST")) u_hp (
        .clka_i(clk), .rsta_n_i(rsta_n), .wr_valid_i(wr_valid), .wr_ready_o(hp_ready),
        .wr_chan_i(wr_chan), .wr_data_i(wr_data), .rd_valid_i(rd_valid), .rd_chan_i(rd_chan),
        .rd_delay_i(rd_delay), .rd_data_o(hp_d), .rd_data_valid_o(hp_v), .rd_underflow_o(hp_uf)
`ifdef RING_CLEAR_EN
        , .clr_i(clr)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic ch, input logic [15:0] d);
        wr_valid = 1'b1; wr_chan = ch; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic issue_read(input logic ch, input logic [2:0] dly);
        rd_valid = 1'b1; rd_chan = ch; rd_delay = dly;
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rsta_n = 1'b0;
        tick(); tick();
        n_vec++; if ({ll_v, ll_uf, ll_d, ll_ready} !== 19'b0) begin n_err++; $display("FAIL reset_ll: got v/uf/d/rdy=%b/%b/%h/%b expected 0/0/0000/0", ll_v, ll_uf, ll_d, ll_ready); end
        n_vec++; if ({hp_v, hp_uf, hp_d, hp_ready} !== 19'b0) begin n_err++; $display("FAIL reset_hp: got v/uf/d/rdy=%b/%b/%h/%b expected 0/0/0000/0", hp_v, hp_uf, hp_d, hp_ready); end
        rsta_n = 1'b1;
        tick();
        n_vec++; if ({ll_ready, hp_ready} !== 2'b11) begin n_err++; $display("FAIL reset_release_ready: got %b%b expected 11", ll_ready, hp_ready); end
    endtask

    task automatic test_basic;
        do_write(1'b0, 16'h0011); do_write(1'b0, 16'h0022); do_write(1'b0, 16'h0033);
        n_vec++; if (ll_v !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid: got %b expected 0", ll_v); end
        issue_read(1'b0, 3'd0);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'h0033}) begin n_err++; $display("FAIL basic_ll_d0: got v/uf/d=%b/%b/%h expected 1/0/0033", ll_v, ll_uf, ll_d); end
        n_vec++; if (hp_v !== 1'b0) begin n_err++; $display("FAIL basic_hp_early: got valid %b expected 0", hp_v); end
        tick();
        n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b10, 16'h0033}) begin n_err++; $display("FAIL basic_hp_d0: got v/uf/d=%b/%b/%h expected 1/0/0033", hp_v, hp_uf, hp_d); end
        n_vec++; if ({ll_v, ll_d} !== {1'b0, 16'h0033}) begin n_err++; $display("FAIL basic_ll_hold: got v/d=%b/%h expected 0/0033", ll_v, ll_d); end
        issue_read(1'b0, 3'd2);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'h0011}) begin n_err++; $display("FAIL basic_ll_d2: got v/uf/d=%b/%b/%h expected 1/0/0011", ll_v, ll_uf, ll_d); end
        tick();
        n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b10, 16'h0011}) begin n_err++; $display("FAIL basic_hp_d2: got v/uf/d=%b/%b/%h expected 1/0/0011", hp_v, hp_uf, hp_d); end
        issue_read(1'b0, 3'd3);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b11, 16'h0000}) begin n_err++; $display("FAIL basic_ll_uf: got v/uf/d=%b/%b/%h expected 1/1/0000", ll_v, ll_uf, ll_d); end
        tick();
        n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b11, 16'h0000}) begin n_err++; $display("FAIL basic_hp_uf: got v/uf/d=%b/%b/%h expected 1/1/0000", hp_v, hp_uf, hp_d); end
    endtask

`ifdef RING_CLEAR_EN
    task automatic test_clear;
        int cnt = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        if (ll_ready !== 1'b1) cnt++;
        issue_read(1'b0, 3'd0);
        if (ll_ready !== 1'b1) cnt++;
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b11, 16'h0000}) begin n_err++; $display("FAIL clear_read_uf: got v/uf/d=%b/%b/%h expected 1/1/0000", ll_v, ll_uf, ll_d); end
        for (int i = 0; i < 40 && ll_ready !== 1'b1; i++) begin
            tick();
            if (ll_ready !== 1'b1) cnt++;
        end
        n_vec++; if (cnt !== 16) begin n_err++; $display("FAIL clear_busy_cycles: got %0d expected 16", cnt); end
        n_vec++; if ({ll_ready, hp_ready} !== 2'b11) begin n_err++; $display("FAIL clear_ready_back: got %b%b expected 11", ll_ready, hp_ready); end
        do_write(1'b0, 16'h0044);
        issue_read(1'b0, 3'd0);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'h0044}) begin n_err++; $display("FAIL clear_new_d0: got v/uf/d=%b/%b/%h expected 1/0/0044", ll_v, ll_uf, ll_d); end
        issue_read(1'b0, 3'd1);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b11, 16'h0000}) begin n_err++; $display("FAIL clear_new_d1: got v/uf/d=%b/%b/%h expected 1/1/0000", ll_v, ll_uf, ll_d); end
        n_vec++; if ({u_ll.mem[1], u_ll.mem[2]} !== 32'h0) begin n_err++; $display("FAIL clear_mem_zero: got %h %h expected 0000 0000", u_ll.mem[1], u_ll.mem[2]); end
        tick();
        ch0_newest = 16'h0044;
    endtask
`endif

    task automatic test_wrap;
        for (int i = 1; i <= 10; i++) do_write(1'b1, 16'(i));
        issue_read(1'b1, 3'd0);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'd10}) begin n_err++; $display("FAIL wrap_ll_d0: got v/uf/d=%b/%b/%h expected 1/0/000a", ll_v, ll_uf, ll_d); end
        tick();
        n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b10, 16'd10}) begin n_err++; $display("FAIL wrap_hp_d0: got v/uf/d=%b/%b/%h expected 1/0/000a", hp_v, hp_uf, hp_d); end
        issue_read(1'b1, 3'd7);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'd3}) begin n_err++; $display("FAIL wrap_ll_d7: got v/uf/d=%b/%b/%h expected 1/0/0003", ll_v, ll_uf, ll_d); end
        tick();
        n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b10, 16'd3}) begin n_err++; $display("FAIL wrap_hp_d7: got v/uf/d=%b/%b/%h expected 1/0/0003", hp_v, hp_uf, hp_d); end
        issue_read(1'b0, 3'd0);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, ch0_newest}) begin n_err++; $display("FAIL wrap_isolation: got v/uf/d=%b/%b/%h expected 1/0/%h", ll_v, ll_uf, ll_d, ch0_newest); end
        tick();
    endtask

    task automatic test_collision;
        for (int i = 1; i <= 8; i++) do_write(1'b0, 16'(i));
        wr_valid = 1'b1; wr_chan = 1'b0; wr_data = 16'd9;
        rd_valid = 1'b1; rd_chan = 1'b0; rd_delay = 3'd7;
        tick();
        wr_valid = 1'b0; rd_valid = 1'b0;
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'd1}) begin n_err++; $display("FAIL coll_read_first: got v/uf/d=%b/%b/%h expected 1/0/0001", ll_v, ll_uf, ll_d); end
        tick();
        n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b10, 16'd9}) begin n_err++; $display("FAIL coll_write_first: got v/uf/d=%b/%b/%h expected 1/0/0009", hp_v, hp_uf, hp_d); end
        issue_read(1'b0, 3'd0);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'd9}) begin n_err++; $display("FAIL coll_after_d0: got v/uf/d=%b/%b/%h expected 1/0/0009", ll_v, ll_uf, ll_d); end
        tick();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1; rd_chan = 1'b1; rd_delay = 3'(i);
            tick();
            n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'(10 - i)}) begin n_err++; $display("FAIL b2b_ll_%0d: got v/uf/d=%b/%b/%h expected 1/0/%h", i, ll_v, ll_uf, ll_d, 16'(10 - i)); end
            if (i > 0) begin
                n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b10, 16'(11 - i)}) begin n_err++; $display("FAIL b2b_hp_%0d: got v/uf/d=%b/%b/%h expected 1/0/%h", i - 1, hp_v, hp_uf, hp_d, 16'(11 - i)); end
            end else begin
                n_vec++; if (hp_v !== 1'b0) begin n_err++; $display("FAIL b2b_hp_first_early: got valid %b expected 0", hp_v); end
            end
        end
        rd_valid = 1'b0;
        tick();
        n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b10, 16'd7}) begin n_err++; $display("FAIL b2b_hp_3: got v/uf/d=%b/%b/%h expected 1/0/0007", hp_v, hp_uf, hp_d); end
        n_vec++; if (ll_v !== 1'b0) begin n_err++; $display("FAIL b2b_ll_drain: got valid %b expected 0", ll_v); end
        tick();
        n_vec++; if (hp_v !== 1'b0) begin n_err++; $display("FAIL b2b_hp_drain: got valid %b expected 0", hp_v); end
    endtask

    task automatic test_reset_mid_read;
        issue_read(1'b0, 3'd0);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b10, 16'd9}) begin n_err++; $display("FAIL rmid_ll_pre: got v/uf/d=%b/%b/%h expected 1/0/0009", ll_v, ll_uf, ll_d); end
        rsta_n = 1'b0;
        tick();
        n_vec++; if ({ll_v, hp_v, ll_ready, hp_ready, ll_d, hp_d} !== 36'h0) begin n_err++; $display("FAIL rmid_in_reset: got llv/hpv/llrdy/hprdy/lld/hpd=%b/%b/%b/%b/%h/%h expected 0/0/0/0/0000/0000", ll_v, hp_v, ll_ready, hp_ready, ll_d, hp_d); end
        rsta_n = 1'b1;
        tick();
        n_vec++; if ({ll_v, hp_v, ll_ready, hp_ready} !== 4'b0011) begin n_err++; $display("FAIL rmid_release: got llv/hpv/llrdy/hprdy=%b/%b/%b/%b expected 0/0/1/1", ll_v, hp_v, ll_ready, hp_ready); end
        issue_read(1'b0, 3'd0);
        n_vec++; if ({ll_v, ll_uf, ll_d} !== {2'b11, 16'h0000}) begin n_err++; $display("FAIL rmid_ll_uf: got v/uf/d=%b/%b/%h expected 1/1/0000", ll_v, ll_uf, ll_d); end
        tick();
        n_vec++; if ({hp_v, hp_uf, hp_d} !== {2'b11, 16'h0000}) begin n_err++; $display("FAIL rmid_hp_uf: got v/uf/d=%b/%b/%h expected 1/1/0000", hp_v, hp_uf, hp_d); end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef RING_CLEAR_EN
        test_clear();
`endif
        test_wrap();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
